// File: rtl/sram_access_seq_if.sv
// Request/response and SRAM pin bundle between the bus arbiter side and the
// SRAM access sequencer.
interface sram_access_seq_if #(
    parameter int ADDR_W = 21
) ();
    logic              req_rd;
    logic              req_wr;
    logic [7:0]        wdata;
    logic [ADDR_W-1:0] addr_load;
    logic              addr_load_en;
    logic              addr_inc;
    logic [7:0]        rdata;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] sram_addr;
    logic [7:0]        sram_data_in;
    logic [7:0]        sram_data_out;
    logic              sram_data_oe;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;

    modport master (
        output req_rd, req_wr, wdata, addr_load, addr_load_en, addr_inc, sram_data_in,
        input  rdata, busy, done, sram_addr, sram_data_out, sram_data_oe,
               sram_ce_n, sram_oe_n, sram_we_n
    );

    modport slave (
        input  req_rd, req_wr, wdata, addr_load, addr_load_en, addr_inc, sram_data_in,
        output rdata, busy, done, sram_addr, sram_data_out, sram_data_oe,
               sram_ce_n, sram_oe_n, sram_we_n
    );
endinterface

// File: rtl/sram_access_seq.sv
// SRAM access sequencer: single-byte reads/writes with SETUP/STROBE/HOLD timing.
// Define SRAM_SEQ_AUTOINC_EN to post-increment the address after every access.
module sram_access_seq #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 21
) (
    input  logic              avr_clk,
    input  logic              avr_reset,
    sram_access_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [3:0] STROBE_LAST = 4'(WAIT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              op_wr, op_wr_nxt;
    logic              busy_nxt, ce_n_nxt, oe_n_nxt, we_n_nxt, doe_nxt, done_nxt;
    logic              busy_q, ce_n_q, oe_n_q, we_n_q, doe_q, done_q;
    logic [7:0]        rdata_q, wdata_q;
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge avr_clk or negedge avr_reset) begin
        if (!avr_reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            op_wr  <= 1'b0;
            busy_q <= 1'b0;
            ce_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            we_n_q <= 1'b1;
            doe_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            op_wr  <= op_wr_nxt;
            busy_q <= busy_nxt;
            ce_n_q <= ce_n_nxt;
            oe_n_q <= oe_n_nxt;
            we_n_q <= we_n_nxt;
            doe_q  <= doe_nxt;
            done_q <= done_nxt;
        end
    end

    // Strobes are registered from the next state so the SRAM pins never glitch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_wr_nxt = op_wr;
        case (state)
            IDLE: begin
                if (bus.req_rd) begin
                    state_nxt = SETUP;
                    op_wr_nxt = 1'b0;
                end else if (bus.req_wr) begin
                    state_nxt = SETUP;
                    op_wr_nxt = 1'b1;
                end
            end
            SETUP: begin
                state_nxt = STROBE;
                cnt_nxt   = STROBE_LAST;
            end
            STROBE: begin
                if (cnt == 4'd0) state_nxt = HOLD;
                else             cnt_nxt   = cnt - 4'd1;
            end
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
        ce_n_nxt = !busy_nxt;
        oe_n_nxt = !((state_nxt == STROBE) && !op_wr_nxt);
        we_n_nxt = !((state_nxt == STROBE) && op_wr_nxt);
        doe_nxt  = busy_nxt && op_wr_nxt;
        done_nxt = (state == HOLD);
    end

    // Address only moves in IDLE so it is frozen from SETUP through HOLD.
    always_ff @(posedge avr_clk or negedge avr_reset) begin
        if (!avr_reset) begin
            rdata_q <= 8'h00;
            wdata_q <= 8'h00;
            addr_q  <= '0;
        end else begin
            if ((state == IDLE) && !bus.req_rd && bus.req_wr) wdata_q <= bus.wdata;
            if ((state == STROBE) && (cnt == 4'd0) && !op_wr) rdata_q <= bus.sram_data_in;
            if (state == IDLE) begin
                if (bus.addr_load_en)  addr_q <= bus.addr_load;
                else if (bus.addr_inc) addr_q <= addr_q + ADDR_W'(1);
            end
`ifdef SRAM_SEQ_AUTOINC_EN
            else if (state == HOLD) addr_q <= addr_q + ADDR_W'(1);
`endif
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.rdata         = rdata_q;
    assign bus.sram_addr     = addr_q;
    assign bus.sram_data_out = wdata_q;
    assign bus.sram_data_oe  = doe_q;
    assign bus.sram_ce_n     = ce_n_q;
    assign bus.sram_oe_n     = oe_n_q;
    assign bus.sram_we_n     = we_n_q;
endmodule

// File: tb/tb_sram_access_seq.sv
// Scoreboard bench for sram_access_seq: directed plus random accesses against
// a behavioural memory/address model and an SRAM pin model.
module tb_sram_access_seq;
    localparam int W  = 2;
    localparam int AW = 21;

    logic avr_clk   = 1'b0;
    logic avr_reset = 1'b0;

    sram_access_seq_if #(.ADDR_W(AW)) bus ();

    sram_access_seq #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
        .avr_clk  (avr_clk),
        .avr_reset(avr_reset),
        .bus      (bus)
    );

    always #5 avr_clk = ~avr_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge avr_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
        logic [7:0]    exp_rdata;
        logic [AW-1:0] post_addr;
        int            cyc0;
    } exp_t;
    exp_t sb[$];

    // Power-on contents of the modelled SRAM.
    function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
        if (a == 21'h1BEEF) return 8'hAA;
        return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h5A;
    endfunction

    function automatic logic [AW-1:0] addr_plus1(input logic [AW-1:0] a);
        int unsigned v;
        v = (int'(a) + 1) % (1 << AW);
        return AW'(v);
    endfunction

    logic [7:0]    ref_mem  [logic [AW-1:0]];
    logic [7:0]    sram_mem [logic [AW-1:0]];
    logic [AW-1:0] model_addr = '0;

    // SRAM pin model
    always @(negedge avr_clk) begin
        if (avr_reset && !bus.sram_ce_n && !bus.sram_oe_n)
            bus.sram_data_in = sram_mem.exists(bus.sram_addr) ? sram_mem[bus.sram_addr]
                                                              : init_byte(bus.sram_addr);
        else
            bus.sram_data_in = 8'($urandom);
        if (avr_reset && !bus.sram_ce_n && !bus.sram_we_n && bus.sram_data_oe)
            sram_mem[bus.sram_addr] = bus.sram_data_out;
    end

    // Monitor
    int            oe_cnt = 0, we_cnt = 0, doe_cnt = 0;
    bit            prev_ce_n = 1'b1;
    logic [AW-1:0] acc_addr = '0;
    always @(negedge avr_clk) begin
        exp_t it;
        if (!avr_reset) begin
            oe_cnt = 0; we_cnt = 0; doe_cnt = 0; prev_ce_n = 1'b1;
        end else begin
            check("strobe_overlap", 32'(!bus.sram_oe_n && !bus.sram_we_n), 32'd0);
            check("busy_vs_ce", 32'(bus.busy), 32'(!bus.sram_ce_n));
            if (!bus.sram_ce_n) begin
                if (prev_ce_n) acc_addr = bus.sram_addr;
                else check("addr_stable", 32'(bus.sram_addr), 32'(acc_addr));
                if (!bus.sram_oe_n) oe_cnt++;
                if (!bus.sram_we_n) we_cnt++;
                if (bus.sram_data_oe) begin
                    doe_cnt++;
                    if (sb.size() > 0) check("wdata_bus", 32'(bus.sram_data_out), 32'(sb[0].wdata));
                end
            end else begin
                check("strobes_idle", {29'd0, bus.sram_oe_n, bus.sram_we_n, bus.sram_data_oe}, 32'd6);
            end
            prev_ce_n = bus.sram_ce_n;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_unexpected: got done=1 expected no pending access");
                end else begin
                    it = sb.pop_front();
                    check("latency", 32'(cyc - it.cyc0), 32'(W + 2));
                    check("access_addr", 32'(acc_addr), 32'(it.addr));
                    check("post_addr", 32'(bus.sram_addr), 32'(it.post_addr));
                    if (it.wr) begin
                        check("we_width", 32'(we_cnt), 32'(W));
                        check("oe_on_write", 32'(oe_cnt), 32'd0);
                        check("doe_cycles", 32'(doe_cnt), 32'(W + 2));
                        check("mem_written", 32'(sram_mem.exists(it.addr) ? sram_mem[it.addr] : 8'hxx),
                              32'(it.wdata));
                    end else begin
                        check("oe_width", 32'(oe_cnt), 32'(W));
                        check("we_on_read", 32'(we_cnt), 32'd0);
                        check("doe_on_read", 32'(doe_cnt), 32'd0);
                        check("rdata", 32'(bus.rdata), 32'(it.exp_rdata));
                    end
                end
                oe_cnt = 0; we_cnt = 0; doe_cnt = 0;
            end
        end
    end

    // Drive point is 2 time units after a rising edge.
    task automatic step();
        @(posedge avr_clk);
        #2;
    endtask

    task automatic clear_ctl();
        bus.req_rd = 1'b0; bus.req_wr = 1'b0;
        bus.addr_load_en = 1'b0; bus.addr_inc = 1'b0;
    endtask

    task automatic ctl(input bit ld, input logic [AW-1:0] la, input bit inc);
        bus.addr_load_en = ld; bus.addr_load = la; bus.addr_inc = inc;
        if (ld) model_addr = la;
        else if (inc) model_addr = addr_plus1(model_addr);
        step();
        clear_ctl();
    endtask

    // kind: 0 read, 1 write, 2 read+write together. Caller is at an idle drive point.
    task automatic access(input int kind, input logic [7:0] wd, input bit ld,
                          input logic [AW-1:0] la, input bit inc, input bit junk);
        exp_t e;
        int   n;
        bus.req_rd = (kind != 1); bus.req_wr = (kind != 0); bus.wdata = wd;
        bus.addr_load_en = ld; bus.addr_load = la; bus.addr_inc = inc;
        if (ld) model_addr = la;
        else if (inc) model_addr = addr_plus1(model_addr);
        e.wr    = (kind == 1);
        e.addr  = model_addr;
        e.wdata = wd;
        e.exp_rdata = ref_mem.exists(model_addr) ? ref_mem[model_addr] : init_byte(model_addr);
        if (e.wr) ref_mem[model_addr] = wd;
`ifdef SRAM_SEQ_AUTOINC_EN
        model_addr = addr_plus1(model_addr);
`endif
        e.post_addr = model_addr;
        @(posedge avr_clk);
        #1;
        e.cyc0 = cyc;
        sb.push_back(e);
        #1;
        clear_ctl();
        bus.wdata = 8'($urandom);
        for (n = 0; n < 40; n++) begin
            if (junk) begin
                bus.addr_load_en = 1'($urandom); bus.addr_inc = 1'($urandom);
                bus.addr_load = AW'($urandom);
            end
            step();
            if (!bus.busy) break;
        end
        clear_ctl();
        if (n == 40) begin
            total++; bad++;
            $display("FAIL access_timeout: busy still 1 after 40 cycles, expected 0");
        end
    endtask

    initial begin
        int n;
        clear_ctl();
        bus.wdata = 8'h00; bus.addr_load = '0;
        repeat (3) @(posedge avr_clk);
        #2;
        check("rst_ce_n", 32'(bus.sram_ce_n), 32'd1);
        check("rst_oe_n", 32'(bus.sram_oe_n), 32'd1);
        check("rst_we_n", 32'(bus.sram_we_n), 32'd1);
        check("rst_doe", 32'(bus.sram_data_oe), 32'd0);
        check("rst_dout", 32'(bus.sram_data_out), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        check("rst_addr", 32'(bus.sram_addr), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        avr_reset = 1'b1;
        step();

        ctl(1'b1, 21'h1BEEF, 1'b0);
        access(0, 8'h00, 1'b0, '0, 1'b0, 1'b0);
        access(1, 8'hEE, 1'b1, 21'h00010, 1'b0, 1'b0);
        access(0, 8'h00, 1'b1, 21'h00010, 1'b0, 1'b0);
        access(2, 8'h33, 1'b1, 21'h00010, 1'b0, 1'b0);
        access(0, 8'h00, 1'b0, '0, 1'b0, 1'b1);
        ctl(1'b1, 21'h1FFFFF, 1'b0);
        access(0, 8'h00, 1'b0, '0, 1'b0, 1'b0);
        access(0, 8'h00, 1'b0, '0, 1'b0, 1'b0);
        access(1, 8'h5C, 1'b1, 21'h1FFFFF, 1'b1, 1'b0);
        access(0, 8'h00, 1'b1, 21'h1FFFFF, 1'b0, 1'b0);
        access(0, 8'h00, 1'b0, '0, 1'b1, 1'b1);

        for (int i = 0; i < 60; i++) begin
            logic [AW-1:0] la;
            la = ($urandom_range(0, 3) == 0) ? AW'(21'h1FFFF8 + $urandom_range(0, 7))
                                             : AW'($urandom_range(0, 7));
            access($urandom_range(0, 2), 8'($urandom), ($urandom_range(0, 2) == 0), la,
                   ($urandom_range(0, 3) == 0), 1'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step();
        end

        // Abort a write in the middle of its strobe.
        access(0, 8'h00, 1'b1, 21'h1BEEF, 1'b0, 1'b0);
        ctl(1'b1, 21'h00020, 1'b0);
        bus.req_wr = 1'b1; bus.wdata = 8'h77;
        step();
        bus.req_wr = 1'b0;
        for (n = 0; n < 10; n++) begin
            if (!bus.sram_we_n) break;
            step();
        end
        check("we_seen_before_reset", 32'(bus.sram_we_n), 32'd0);
        avr_reset = 1'b0;
        #1;
        check("arst_we_n", 32'(bus.sram_we_n), 32'd1);
        check("arst_oe_n", 32'(bus.sram_oe_n), 32'd1);
        check("arst_ce_n", 32'(bus.sram_ce_n), 32'd1);
        check("arst_doe", 32'(bus.sram_data_oe), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_rdata", 32'(bus.rdata), 32'd0);
        check("arst_addr", 32'(bus.sram_addr), 32'd0);
        step();
        step();
        avr_reset = 1'b1;
        repeat (8) step();
        check("arst_busy_after", 32'(bus.busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at 300000, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
